// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: ALU opcodes and the program-counter width,
// used by the execute datapath and the main control decoder.
package rv32i_pkg;

  localparam int PC_W = 8;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_SLL    = 4'b0010,
    ALU_SLT    = 4'b0011,
    ALU_SLTU   = 4'b0100,
    ALU_XOR    = 4'b0101,
    ALU_SRL    = 4'b0110,
    ALU_SRA    = 4'b0111,
    ALU_OR     = 4'b1000,
    ALU_AND    = 4'b1001,
    ALU_PASS_B = 4'b1010
  } alu_op_e;

endpackage

// File: rtl/alu_branch_unit_if.sv
// Operand, control and result bundle between the ID/EX muxes, the execute
// block and the PC-select logic.
interface alu_branch_unit_if #(parameter int PC_W = rv32i_pkg::PC_W);

  logic [31:0]     alu_a;
  logic [31:0]     alu_b;
  logic [3:0]      alu_sel;
  logic [31:0]     alu_result;
  logic [31:0]     alu_result_q;
  logic [31:0]     rd1;
  logic [31:0]     rd2;
  logic            bru;
  logic            br_eq;
  logic            br_lt;
  logic            pc_sel;
  logic [31:0]     imm;
  logic [PC_W-1:0] id_pc;
  logic [PC_W-1:0] pc_branch;
  logic            branch;

  modport master (
    output alu_a, alu_b, alu_sel, rd1, rd2, bru, pc_sel, imm, id_pc,
    input  alu_result, alu_result_q, br_eq, br_lt, pc_branch, branch
  );

  modport slave (
    input  alu_a, alu_b, alu_sel, rd1, rd2, bru, pc_sel, imm, id_pc,
    output alu_result, alu_result_q, br_eq, br_lt, pc_branch, branch
  );

endinterface

// File: rtl/rv32i_alu.sv
// Purely combinational 32-bit RV32I integer ALU.
module rv32i_alu
  import rv32i_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] result_o
);

  logic [4:0] shamt;

  assign shamt = b_i[4:0];

  // Unassigned opcodes return zero so a stray code can never leak operands.
  always_comb begin
    result_o = '0;
    case (sel_i)
      ALU_ADD:    result_o = a_i + b_i;
      ALU_SUB:    result_o = a_i - b_i;
      ALU_SLL:    result_o = a_i << shamt;
      ALU_SLT:    result_o = {31'b0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU:   result_o = {31'b0, a_i < b_i};
      ALU_XOR:    result_o = a_i ^ b_i;
      ALU_SRL:    result_o = a_i >> shamt;
      ALU_SRA:    result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_OR:     result_o = a_i | b_i;
      ALU_AND:    result_o = a_i & b_i;
      ALU_PASS_B: result_o = b_i;
      default:    result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_branch_unit.sv
// Execute-stage ALU with EX/MEM result register, plus the ID-stage branch
// comparator and branch-target adder.
module alu_branch_unit #(
  parameter int PC_W = rv32i_pkg::PC_W
) (
  input logic               clk,
  input logic               rst,
  alu_branch_unit_if.slave  bus
);

  logic [31:0] result_d;
  logic [31:0] result_q;
  logic        unused_imm;

  rv32i_alu u_alu (
    .a_i      (bus.alu_a),
    .b_i      (bus.alu_b),
    .sel_i    (bus.alu_sel),
    .result_o (result_d)
  );

  assign bus.alu_result = result_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign bus.alu_result_q = result_q;

  assign bus.br_eq = (bus.rd1 == bus.rd2);
  assign bus.br_lt = bus.bru ? (bus.rd1 < bus.rd2)
                             : ($signed(bus.rd1) < $signed(bus.rd2));

  // Target wraps within the small instruction memory; upper imm bits are dropped.
  assign bus.pc_branch = bus.id_pc + bus.imm[PC_W-1:0];
  assign bus.branch    = bus.pc_sel;
  assign unused_imm    = ^bus.imm[31:PC_W];

endmodule

// File: tb/tb_alu_branch_unit.sv
// Self-checking bench for alu_branch_unit: directed cases plus randomized
// traffic compared every cycle against an arithmetic reference model.
module tb_alu_branch_unit;

  localparam logic [31:0] MSB = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        checking;
  logic [31:0] expQ;
  int          passCount;
  int          checkCount;

  alu_branch_unit_if #(.PC_W(8)) bus ();

  alu_branch_unit #(.PC_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] modelAlu(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    int unsigned s;
    s = b & 32'd31;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << s;
      4'd3:    return ((a ^ MSB) < (b ^ MSB)) ? 32'd1 : 32'd0;
      4'd4:    return (a < b) ? 32'd1 : 32'd0;
      4'd5:    return a ^ b;
      4'd6:    return a >> s;
      4'd7:    return (a >> s) | ((a >= MSB) ? ~(32'hFFFF_FFFF >> s) : 32'd0);
      4'd8:    return a | b;
      4'd9:    return a & b;
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic modelLt(input logic [31:0] x, input logic [31:0] y,
                                   input logic unsignedCmp);
    if (unsignedCmp) return x < y;
    return (x ^ MSB) < (y ^ MSB);
  endfunction

  function automatic logic [31:0] modelPc(input logic [7:0] pc, input logic [31:0] im);
    int unsigned sum;
    sum = (int'(pc) + (im % 256)) % 256;
    return sum;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h, required %h at %0t", name, actual, expected, $time);
    else
      passCount++;
  endtask

  task automatic applyStimulus(input logic [3:0] sel, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] r1,
                               input logic [31:0] r2, input logic unsignedCmp,
                               input logic pcSel, input logic [31:0] im,
                               input logic [7:0] pc);
    @(posedge clk);
    #2;
    bus.alu_sel = sel;
    bus.alu_a   = a;
    bus.alu_b   = b;
    bus.rd1     = r1;
    bus.rd2     = r2;
    bus.bru     = unsignedCmp;
    bus.pc_sel  = pcSel;
    bus.imm     = im;
    bus.id_pc   = pc;
    #1;
  endtask

  // Expected registered result: cleared by reset, otherwise last edge's ALU value.
  always @(posedge clk or posedge rst) begin
    if (rst) expQ <= 32'd0;
    else     expQ <= modelAlu(bus.alu_sel, bus.alu_a, bus.alu_b);
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("alu_result", bus.alu_result, modelAlu(bus.alu_sel, bus.alu_a, bus.alu_b));
      checkOutput("alu_result_q", bus.alu_result_q, expQ);
      checkOutput("br_eq", {31'b0, bus.br_eq}, {31'b0, bus.rd1 == bus.rd2});
      checkOutput("br_lt", {31'b0, bus.br_lt}, {31'b0, modelLt(bus.rd1, bus.rd2, bus.bru)});
      checkOutput("pc_branch", {24'b0, bus.pc_branch}, modelPc(bus.id_pc, bus.imm));
      checkOutput("branch", {31'b0, bus.branch}, {31'b0, bus.pc_sel});
    end
  end

  initial begin
    logic [31:0] ra, rb, r1;
    passCount   = 0;
    checkCount  = 0;
    checking    = 1'b0;
    expQ        = 32'd0;
    rst         = 1'b1;
    bus.alu_sel = 4'd0;
    bus.alu_a   = 32'd0;
    bus.alu_b   = 32'd0;
    bus.rd1     = 32'd0;
    bus.rd2     = 32'd0;
    bus.bru     = 1'b0;
    bus.pc_sel  = 1'b0;
    bus.imm     = 32'd0;
    bus.id_pc   = 8'd0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset q held", bus.alu_result_q, 32'd0);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("reset q released", bus.alu_result_q, 32'd0);
    checking = 1'b1;

    checkOutput("model add", modelAlu(4'd0, 32'h7FFF_FFFF, 32'd1), 32'h8000_0000);
    checkOutput("model sra", modelAlu(4'd7, 32'h8000_0010, 32'h24), 32'hF800_0001);
    checkOutput("model slt", modelAlu(4'd3, 32'hFFFF_FFFF, 32'd1), 32'd1);

    applyStimulus(4'd0, 32'h7FFF_FFFF, 32'd1, 0, 0, 0, 0, 0, 0);
    checkOutput("add wrap", bus.alu_result, 32'h8000_0000);
    applyStimulus(4'd1, 32'd0, 32'd1, 0, 0, 0, 0, 0, 0);
    checkOutput("sub wrap", bus.alu_result, 32'hFFFF_FFFF);
    applyStimulus(4'd3, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 0, 0);
    checkOutput("slt", bus.alu_result, 32'd1);
    applyStimulus(4'd4, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 0, 0);
    checkOutput("sltu", bus.alu_result, 32'd0);
    applyStimulus(4'd2, 32'h8000_0010, 32'h24, 0, 0, 0, 0, 0, 0);
    checkOutput("sll", bus.alu_result, 32'h0000_0100);
    applyStimulus(4'd6, 32'h8000_0010, 32'h24, 0, 0, 0, 0, 0, 0);
    checkOutput("srl", bus.alu_result, 32'h0800_0001);
    applyStimulus(4'd7, 32'h8000_0010, 32'h24, 0, 0, 0, 0, 0, 0);
    checkOutput("sra", bus.alu_result, 32'hF800_0001);
    applyStimulus(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0, 0, 0, 0);
    checkOutput("undefined op", bus.alu_result, 32'd0);

    applyStimulus(4'd0, 0, 0, 32'hFFFF_FFFE, 32'd2, 1'b0, 0, 0, 0);
    checkOutput("signed lt", {31'b0, bus.br_lt}, 32'd1);
    checkOutput("signed ne", {31'b0, bus.br_eq}, 32'd0);
    applyStimulus(4'd0, 0, 0, 32'hFFFF_FFFE, 32'd2, 1'b1, 0, 0, 0);
    checkOutput("unsigned lt", {31'b0, bus.br_lt}, 32'd0);
    applyStimulus(4'd0, 0, 0, 32'd5, 32'd5, 1'b0, 0, 0, 0);
    checkOutput("eq", {31'b0, bus.br_eq}, 32'd1);
    checkOutput("eq not lt", {31'b0, bus.br_lt}, 32'd0);

    applyStimulus(4'd0, 0, 0, 0, 0, 0, 1'b1, 32'h0000_0010, 8'hF8);
    checkOutput("target wrap", {24'b0, bus.pc_branch}, 32'h08);
    checkOutput("branch taken", {31'b0, bus.branch}, 32'd1);
    applyStimulus(4'd0, 0, 0, 0, 0, 0, 1'b1, 32'hFFFF_FFF8, 8'h10);
    checkOutput("target negative", {24'b0, bus.pc_branch}, 32'h08);
    applyStimulus(4'd0, 0, 0, 0, 0, 0, 1'b0, 32'hFFFF_FFF8, 8'h10);
    checkOutput("branch not taken", {31'b0, bus.branch}, 32'd0);

    applyStimulus(4'd8, 32'hF0, 32'h0F, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    checkOutput("q after edge", bus.alu_result_q, 32'hFF);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("q async clear", bus.alu_result_q, 32'd0);
    checkOutput("comb during reset", bus.alu_result, 32'hFF);
    @(posedge clk);
    #1;
    checkOutput("q held in reset", bus.alu_result_q, 32'd0);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("q before first edge", bus.alu_result_q, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("q first capture", bus.alu_result_q, 32'hFF);

    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = $urandom;
      r1 = $urandom;
      applyStimulus(4'($urandom_range(0, 15)), ra, rb, r1,
                    ($urandom_range(0, 3) == 0) ? r1 : 32'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom, 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        #1;
        rst = 1'b0;
      end
    end

    @(posedge clk);
    #1;
    checking = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/alu_branch_unit.md
# alu_branch_unit

Execute-and-branch datapath block for the 5-stage RV32I pipeline. It combines three functions: the 32-bit integer ALU, the decode-stage branch comparator and the branch-target generator. It also registers the ALU result into the EX/MEM boundary. The block sits between the ID/EX operand muxes and the EX/MEM stage; its branch outputs feed the PC-select logic.

## Interface
Parameters:
- `PC_W`, 8: program-counter width (instruction memory is byte-addressed, 256 B).

Ports:
- `clk`  in  1  clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `alu_a`  in  32  ALU operand A (already forwarded/selected).
- `alu_b`  in  32  ALU operand B (already forwarded/selected).
- `alu_sel`  in  4  ALU operation code.
- `alu_result`  out  32  combinational ALU result.
- `alu_result_q`  out  32  `alu_result` registered on `clk`.
- `rd1`, `rd2`  in  32 each  register-file read data for branch compare.
- `bru`  in  1  1 = unsigned compare, 0 = signed compare.
- `br_eq`  out  1  `rd1 == rd2`.
- `br_lt`  out  1  `rd1 < rd2` under `bru`.
- `pc_sel`  in  1  control: branch/jump taken.
- `imm`  in  32  sign-extended B/J immediate.
- `id_pc`  in  `PC_W`  PC of the instruction in ID.
- `pc_branch`  out  `PC_W`  branch target.
- `branch`  out  1  redirect request (flushes IF/ID).

## Operation
ALU (combinational). `alu_sel` encodes:
- 0000 ADD
- 0001 SUB
- 0010 SLL
- 0011 SLT
- 0100 SLTU
- 0101 XOR
- 0110 SRL
- 0111 SRA
- 1000 OR
- 1001 AND
- 1010 PASS_B (LUI)
- 1011–1111 → result 0

ALU arithmetic rules:
- ADD/SUB wrap modulo 2^32; no overflow flag.
- Shift amount is `alu_b[4:0]` only; SRA replicates `alu_a[31]`.
- SLT/SLTU produce 32'h0000_0001 or 32'h0000_0000.
- Code 0000 doubles as the pipeline-bubble code, so ADD must be harmless with any operands.

Branch comparator (combinational):
- `br_eq` is independent of `bru`.
- `br_lt` uses a two's-complement compare when `bru`=0 and a magnitude compare when `bru`=1.
- Equal operands give `br_lt`=0.

Branch control (combinational):
- `pc_branch = id_pc + imm[PC_W-1:0]`, wrapping modulo 2^`PC_W`; upper `imm` bits are ignored.
- `branch = pc_sel`.
- Stall gating of `branch` is done outside this block.

## Timing
- `alu_result`, `br_eq`, `br_lt`, `pc_branch` and `branch` have zero latency: pure functions of the current inputs, with no dependence on `clk`.
- `alu_result_q` has a latency of 1 cycle: it captures `alu_result` at each rising `clk`, with no enable.
- Reset behaviour of `alu_result_q`:
  - Asynchronous `rst`=1 forces it to 0 immediately and holds 0 while asserted.
  - The first capture happens at the first rising edge after deassertion.
- Reset mid-operation clears only `alu_result_q`; the combinational outputs keep tracking their inputs during reset.
- No handshakes and no state machine.

## Structure
- Shared package `rv32i_pkg`: ALU opcode constants (`ALU_ADD` … `ALU_PASS_B`) and `PC_W`, shared with the main control decoder.
- Natural sub-module: `rv32i_alu` (pure combinational ALU), instantiated once.
- Comparator, target adder and result register stay inline in `alu_branch_unit`.

## Test plan
- **ADD/SUB/SLT.** Stimulus:
  - ADD with a=32'h7FFF_FFFF, b=1.
  - SUB with a=0, b=1.
  - SLT with a=32'hFFFF_FFFF, b=1.
  - SLTU with the same operands.

  Required results: 32'h8000_0000, 32'hFFFF_FFFF, 1 and 0 respectively.
- **Shifts.** Stimulus, with a=32'h8000_0010 and b=32'h0000_0024:
  - SLL
  - SRL
  - SRA

  Required results (shift amount 4): 32'h0000_0100, 32'h0800_0001 and 32'hF800_0001 respectively.
- **Branch compare.** Stimulus: rd1=32'hFFFF_FFFE, rd2=2. Required: `bru`=0 → `br_lt`=1, `br_eq`=0; `bru`=1 → `br_lt`=0. With rd1=rd2=5: `br_eq`=1, `br_lt`=0.
- **Branch target.** Stimulus and required response:
  - `id_pc`=8'hF8, `imm`=32'h0000_0010, `pc_sel`=1 → `pc_branch`=8'h08 (wrap), `branch`=1.
  - `imm`=32'hFFFF_FFF8, `id_pc`=8'h10 → `pc_branch`=8'h08.
  - `pc_sel`=0 → `branch`=0.
- **Register/reset.** Stimulus: apply OR, a=32'hF0, b=32'h0F; clock once; then assert `rst` between edges. Required: `alu_result_q`=32'hFF after the edge, drops to 0 without a clock edge, and stays 0 until the first edge after release.
- **Undefined opcode.** Stimulus: `alu_sel`=4'b1111 with nonzero operands. Required: `alu_result`=0.
